// File: rtl/l2_ctrl_pkg.sv
// Shared types, default channel counts and the masked-reduction helper for the L2 row-loop controller.
package l2_ctrl_pkg;

   localparam int unsigned DEF_NUM_CH = 32;
   localparam int unsigned DEF_ROW_W  = 7;
   localparam int unsigned MAX_CH     = 256;
   localparam int unsigned STATE_W    = 3;

   typedef logic [STATE_W-1:0] l2_state_t;

   localparam l2_state_t ST_IDLE        = 3'd0;
   localparam l2_state_t ST_LOAD_IPSUM  = 3'd1;
   localparam l2_state_t ST_FLOW        = 3'd2;
   localparam l2_state_t ST_STORE_OPSUM = 3'd3;
   localparam l2_state_t ST_DRAIN       = 3'd4;
   localparam l2_state_t ST_ROW_NEXT    = 3'd5;
   localparam l2_state_t ST_DONE        = 3'd6;

   // Zero-extended mask bits become don't-care, so narrower groups reduce correctly.
   function automatic logic masked_all(input logic [MAX_CH-1:0] flag,
                                       input logic [MAX_CH-1:0] mask);
      return &(flag | ~mask);
   endfunction

endpackage

// File: rtl/l2_mask_reduce.sv
// Masked all-done / all-empty reduction for one FIFO group; disabled channels count as done and empty.
module l2_mask_reduce
   import l2_ctrl_pkg::*;
#(
   parameter int unsigned W = DEF_NUM_CH
) (
   input  logic [W-1:0] done_i,
   input  logic [W-1:0] empty_i,
   input  logic [W-1:0] mask_i,
   output logic         all_done_o,
   output logic         all_empty_o
);

   assign all_done_o  = masked_all(MAX_CH'(done_i),  MAX_CH'(mask_i));
   assign all_empty_o = masked_all(MAX_CH'(empty_i), MAX_CH'(mask_i));

endmodule

// File: rtl/l2_row_loop_ctrl.sv
// Row-loop controller for the normal convolution phase: preload, flow, store and drain per ofmap row.
// Optional stall counter enabled by defining L2_ROW_LOOP_PERF_EN.
module l2_row_loop_ctrl
   import l2_ctrl_pkg::*;
#(
   parameter int unsigned NUM_IFMAP = DEF_NUM_CH,
   parameter int unsigned NUM_IPSUM = DEF_NUM_CH,
   parameter int unsigned NUM_OPSUM = DEF_NUM_CH,
   parameter int unsigned ROW_W     = DEF_ROW_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic [ROW_W-1:0]     num_rows_i,
   input  logic                 skip_ipsum_i,
   input  logic [NUM_IFMAP-1:0] ifmap_en_i,
   input  logic [NUM_IPSUM-1:0] ipsum_en_i,
   input  logic [NUM_OPSUM-1:0] opsum_en_i,
   input  logic [NUM_IFMAP-1:0] ifmap_done_i,
   input  logic [NUM_IPSUM-1:0] ipsum_done_i,
   input  logic [NUM_OPSUM-1:0] opsum_done_i,
   input  logic [NUM_IFMAP-1:0] ifmap_empty_i,
   input  logic [NUM_IPSUM-1:0] ipsum_empty_i,
   input  logic [NUM_OPSUM-1:0] opsum_empty_i,
   output logic [NUM_IFMAP-1:0] ifmap_need_pop_o,
   output logic [NUM_IPSUM-1:0] ipsum_need_push_o,
   output logic [NUM_OPSUM-1:0] opsum_need_pop_o,
   output logic                 pe_stall_o,
   output logic                 busy_o,
   output logic [ROW_W-1:0]     row_idx_o,
   output logic                 row_done_o,
   output logic                 normal_done_o
`ifdef L2_ROW_LOOP_PERF_EN
   ,
   output logic [31:0]          stall_cnt_o
`endif
);

   l2_state_t              state_q,    state_d;
   logic [ROW_W-1:0]       row_idx_q,  row_idx_d;
   logic [ROW_W-1:0]       num_rows_q, num_rows_d;
   logic                   skip_q,     skip_d;
   logic [NUM_IFMAP-1:0]   ifmap_en_q, ifmap_en_d;
   logic [NUM_IPSUM-1:0]   ipsum_en_q, ipsum_en_d;
   logic [NUM_OPSUM-1:0]   opsum_en_q, opsum_en_d;

   logic ifmap_all_done, ifmap_all_empty;
   logic ipsum_all_done, ipsum_all_empty;
   logic opsum_all_done, opsum_all_empty;
   logic last_row;

`ifdef L2_ROW_LOOP_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
`endif

   l2_mask_reduce #(.W(NUM_IFMAP)) u_ifmap_red (
      .done_i      (ifmap_done_i),
      .empty_i     (ifmap_empty_i),
      .mask_i      (ifmap_en_q),
      .all_done_o  (ifmap_all_done),
      .all_empty_o (ifmap_all_empty)
   );

   l2_mask_reduce #(.W(NUM_IPSUM)) u_ipsum_red (
      .done_i      (ipsum_done_i),
      .empty_i     (ipsum_empty_i),
      .mask_i      (ipsum_en_q),
      .all_done_o  (ipsum_all_done),
      .all_empty_o (ipsum_all_empty)
   );

   l2_mask_reduce #(.W(NUM_OPSUM)) u_opsum_red (
      .done_i      (opsum_done_i),
      .empty_i     (opsum_empty_i),
      .mask_i      (opsum_en_q),
      .all_done_o  (opsum_all_done),
      .all_empty_o (opsum_all_empty)
   );

   assign last_row = (row_idx_q == (num_rows_q - ROW_W'(1)));

   // Next-state, config latch and combinational request outputs.
   always_comb begin
      state_d           = state_q;
      row_idx_d         = row_idx_q;
      num_rows_d        = num_rows_q;
      skip_d            = skip_q;
      ifmap_en_d        = ifmap_en_q;
      ipsum_en_d        = ipsum_en_q;
      opsum_en_d        = opsum_en_q;
      ifmap_need_pop_o  = '0;
      ipsum_need_push_o = '0;
      opsum_need_pop_o  = '0;
      pe_stall_o        = 1'b1;
      busy_o            = 1'b1;
      row_done_o        = 1'b0;
      normal_done_o     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            busy_o = 1'b0;
            if (start_i) begin
               num_rows_d = num_rows_i;
               skip_d     = skip_ipsum_i;
               ifmap_en_d = ifmap_en_i;
               // Skipping ipsum is folded into the latched mask so every use sees it.
               ipsum_en_d = skip_ipsum_i ? '0 : ipsum_en_i;
               opsum_en_d = opsum_en_i;
               row_idx_d  = '0;
               if (num_rows_i == '0)
                  state_d = ST_DONE;
               else if (skip_ipsum_i)
                  state_d = ST_FLOW;
               else
                  state_d = ST_LOAD_IPSUM;
            end
         end
         ST_LOAD_IPSUM: begin
            ipsum_need_push_o = ipsum_en_q & ~ipsum_done_i;
            if (ipsum_all_done)
               state_d = ST_FLOW;
         end
         ST_FLOW: begin
            ifmap_need_pop_o  = ifmap_en_q & ~ifmap_done_i;
            ipsum_need_push_o = ipsum_en_q & ~ipsum_done_i;
            opsum_need_pop_o  = opsum_en_q & ~opsum_done_i;
            pe_stall_o        = (|ifmap_need_pop_o) | (|ipsum_need_push_o);
            if (ifmap_all_done && ipsum_all_done)
               state_d = ST_STORE_OPSUM;
         end
         ST_STORE_OPSUM: begin
            opsum_need_pop_o = opsum_en_q & ~opsum_done_i;
            if (opsum_all_done)
               state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (ifmap_all_empty && ipsum_all_empty && opsum_all_empty)
               state_d = ST_ROW_NEXT;
         end
         ST_ROW_NEXT: begin
            row_done_o = 1'b1;
            if (last_row) begin
               state_d = ST_DONE;
            end else begin
               row_idx_d = row_idx_q + ROW_W'(1);
               state_d   = skip_q ? ST_FLOW : ST_LOAD_IPSUM;
            end
         end
         ST_DONE: begin
            normal_done_o = 1'b1;
            state_d       = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

`ifdef L2_ROW_LOOP_PERF_EN
      stall_cnt_d = stall_cnt_q;
      if (state_q == ST_IDLE && start_i)
         stall_cnt_d = '0;
      else if (state_q == ST_FLOW && pe_stall_o && stall_cnt_q != 32'hFFFF_FFFF)
         stall_cnt_d = stall_cnt_q + 32'd1;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         row_idx_q  <= '0;
         num_rows_q <= '0;
         skip_q     <= 1'b0;
         ifmap_en_q <= '0;
         ipsum_en_q <= '0;
         opsum_en_q <= '0;
      end else begin
         state_q    <= state_d;
         row_idx_q  <= row_idx_d;
         num_rows_q <= num_rows_d;
         skip_q     <= skip_d;
         ifmap_en_q <= ifmap_en_d;
         ipsum_en_q <= ipsum_en_d;
         opsum_en_q <= opsum_en_d;
      end
   end

`ifdef L2_ROW_LOOP_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt_q <= '0;
      else
         stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt_o = stall_cnt_q;
`endif

   assign row_idx_o = row_idx_q;

endmodule

// File: tb/tb_l2_row_loop_ctrl.sv
// Self-checking bench for l2_row_loop_ctrl: the bench plays L1 and the L3 engines and predicts outputs per row phase.
module tb_l2_row_loop_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start_i;
   logic [6:0]  num_rows_i;
   logic        skip_ipsum_i;
   logic [31:0] ifmap_en_i, ipsum_en_i, opsum_en_i;
   logic [31:0] ifmap_done_i, ipsum_done_i, opsum_done_i;
   logic [31:0] ifmap_empty_i, ipsum_empty_i, opsum_empty_i;
   logic [31:0] ifmap_need_pop, ipsum_need_push, opsum_need_pop;
   logic        pe_stall, busy, row_done, normal_done;
   logic [6:0]  row_idx;
`ifdef L2_ROW_LOOP_PERF_EN
   logic [31:0] stall_cnt;
`endif

   int checks   = 0;
   int failures = 0;
   int exp_row  = 0;

   l2_row_loop_ctrl dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .start_i           (start_i),
      .num_rows_i        (num_rows_i),
      .skip_ipsum_i      (skip_ipsum_i),
      .ifmap_en_i        (ifmap_en_i),
      .ipsum_en_i        (ipsum_en_i),
      .opsum_en_i        (opsum_en_i),
      .ifmap_done_i      (ifmap_done_i),
      .ipsum_done_i      (ipsum_done_i),
      .opsum_done_i      (opsum_done_i),
      .ifmap_empty_i     (ifmap_empty_i),
      .ipsum_empty_i     (ipsum_empty_i),
      .opsum_empty_i     (opsum_empty_i),
      .ifmap_need_pop_o  (ifmap_need_pop),
      .ipsum_need_push_o (ipsum_need_push),
      .opsum_need_pop_o  (opsum_need_pop),
      .pe_stall_o        (pe_stall),
      .busy_o            (busy),
      .row_idx_o         (row_idx),
      .row_done_o        (row_done),
      .normal_done_o     (normal_done)
`ifdef L2_ROW_LOOP_PERF_EN
      ,
      .stall_cnt_o       (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Check all outputs #1 after inputs were driven on the falling edge, then move to the next falling edge.
   task automatic cyc(input logic [31:0] e_pop_f, input logic [31:0] e_push_i,
                      input logic [31:0] e_pop_o, input int e_stall, input bit e_busy,
                      input bit e_rd, input bit e_nd, input int e_row);
      #1;
      chk("ifmap_need_pop", ifmap_need_pop, e_pop_f);
      chk("ipsum_need_push", ipsum_need_push, e_push_i);
      chk("opsum_need_pop", opsum_need_pop, e_pop_o);
      if (e_stall >= 0) chk("pe_stall", 32'(pe_stall), 32'(e_stall));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("row_done", 32'(row_done), 32'(e_rd));
      chk("normal_done", 32'(normal_done), 32'(e_nd));
      chk("row_idx", 32'(row_idx), 32'(e_row));
      @(negedge clk);
   endtask

   // Group done/empty pattern: complete over the mask, or missing at least one enabled channel.
   function automatic logic [31:0] grp(input bit full, input logic [31:0] m);
      logic [31:0] v;
      v = $urandom;
      if (full) return m | (v & ~m);
      if ((v & m) == m) v = v & ~(m & (~m + 32'd1));
      return v;
   endfunction

   function automatic int dly(input bit directed, input int dd, input logic [31:0] m);
      if (m == 32'd0) return 0;
      return directed ? dd : int'($urandom_range(0, 4));
   endfunction

   task automatic rnd_levels();
      ifmap_done_i  = $urandom; ipsum_done_i  = $urandom; opsum_done_i  = $urandom;
      ifmap_empty_i = $urandom; ipsum_empty_i = $urandom; opsum_empty_i = $urandom;
   endtask

   task automatic run_pass(input int nrows, input bit skip, input logic [31:0] mf,
                           input logic [31:0] mi, input logic [31:0] mo, input bit directed,
                           input bit glitch, input bit rst_flow);
      logic [31:0] mie;
      int d0, d1, d2, n;
      mie = skip ? 32'd0 : mi;
      start_i = 1'b1; num_rows_i = 7'(nrows); skip_ipsum_i = skip;
      ifmap_en_i = mf; ipsum_en_i = mi; opsum_en_i = mo;
      rnd_levels();
      cyc(0, 0, 0, 1, 0, 0, 0, exp_row);
      start_i = 1'b0;
      exp_row = 0;
      if (nrows == 0) begin
         rnd_levels();
         cyc(0, 0, 0, -1, 1, 0, 1, 0);
         return;
      end
      for (int r = 0; r < nrows; r++) begin
         if (!skip) begin
            d0 = dly(directed, 3, mie);
            for (int c = 0; c <= d0; c++) begin
               rnd_levels();
               ipsum_done_i = grp(c >= d0, mie);
               cyc(0, mie & ~ipsum_done_i, 0, 1, 1, 0, 0, r);
            end
         end
         d0 = dly(directed, 10, mf);
         d1 = dly(directed, 10, mie);
         n  = (d0 > d1) ? d0 : d1;
         for (int c = 0; c <= n; c++) begin
            rnd_levels();
            ifmap_done_i = grp(c >= d0, mf);
            ipsum_done_i = grp(c >= d1, mie);
            if (rst_flow) begin
               rst_n = 1'b0;
               #1;
               chk("rst_ifmap_need_pop", ifmap_need_pop, 0);
               chk("rst_ipsum_need_push", ipsum_need_push, 0);
               chk("rst_opsum_need_pop", opsum_need_pop, 0);
               chk("rst_pe_stall", 32'(pe_stall), 1);
               chk("rst_busy", 32'(busy), 0);
               chk("rst_row_idx", 32'(row_idx), 0);
               @(negedge clk);
               rst_n = 1'b1;
               exp_row = 0;
               cyc(0, 0, 0, 1, 0, 0, 0, 0);
               return;
            end
            if (glitch && r == 0 && c == 0) begin
               start_i = 1'b1; num_rows_i = 7'd0; skip_ipsum_i = ~skip;
               ifmap_en_i = $urandom; ipsum_en_i = $urandom; opsum_en_i = $urandom;
            end
            cyc(mf & ~ifmap_done_i, mie & ~ipsum_done_i, mo & ~opsum_done_i,
                int'(|(mf & ~ifmap_done_i) | |(mie & ~ipsum_done_i)), 1, 0, 0, r);
            start_i = 1'b0;
         end
         d0 = dly(directed, 2, mo);
         for (int c = 0; c <= d0; c++) begin
            rnd_levels();
            opsum_done_i = grp(c >= d0, mo);
            cyc(0, 0, mo & ~opsum_done_i, 1, 1, 0, 0, r);
         end
         d0 = dly(directed, 1, mf);
         d1 = dly(directed, 1, mie);
         d2 = dly(directed, 1, mo);
         n  = (d0 > d1) ? d0 : d1;
         n  = (n > d2) ? n : d2;
         for (int c = 0; c <= n; c++) begin
            rnd_levels();
            ifmap_empty_i = grp(c >= d0, mf);
            ipsum_empty_i = grp(c >= d1, mie);
            opsum_empty_i = grp(c >= d2, mo);
            cyc(0, 0, 0, 1, 1, 0, 0, r);
         end
         rnd_levels();
         cyc(0, 0, 0, 1, 1, 1, 0, r);
      end
      rnd_levels();
      cyc(0, 0, 0, -1, 1, 0, 1, nrows - 1);
      exp_row = nrows - 1;
   endtask

   function automatic logic [31:0] rnd_mask();
      case ($urandom_range(0, 3))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h0000_00FF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst_n = 1'b0; start_i = 1'b0; num_rows_i = '0; skip_ipsum_i = 1'b0;
      ifmap_en_i = '0; ipsum_en_i = '0; opsum_en_i = '0;
      rnd_levels();
      @(negedge clk);
      cyc(0, 0, 0, 1, 0, 0, 0, 0);
      rst_n = 1'b1;
      cyc(0, 0, 0, 1, 0, 0, 0, 0);

      run_pass(1, 0, '1, '1, '1, 1, 0, 0);
      run_pass(4, 0, '1, '1, '1, 0, 0, 0);
      run_pass(2, 0, 32'h0000_00FF, '1, '1, 0, 0, 0);
      run_pass(2, 1, '1, '1, '1, 0, 0, 0);
      run_pass(0, 0, '1, '1, '1, 0, 0, 0);
      run_pass(3, 0, 32'h0000_FFFF, 32'hF0F0_F0F0, 32'h0000_000F, 0, 1, 0);
      run_pass(2, 0, '1, '1, '1, 0, 0, 1);
      run_pass(1, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
      for (int i = 0; i < 8; i++)
         run_pass(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)),
                  rnd_mask(), rnd_mask(), rnd_mask(), 0, 0, 0);
      rnd_levels();
      cyc(0, 0, 0, 1, 0, 0, 0, exp_row);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
